// File: rtl/multiplier_arbiter_tainttrack.sv
// Round-robin arbiter/sequencer for one shared taint-tracked multiplier; request-to-done latency is 3 + multiplier latency.
// Requests are only sampled in IDLE, so requesters hold req/operands until ack; every output is registered.
module multiplier_arbiter_tainttrack #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic               req0_t,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   a0_t,
   input  logic [WIDTH-1:0]   b0,
   input  logic [WIDTH-1:0]   b0_t,
   input  logic               req1,
   input  logic               req1_t,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   a1_t,
   input  logic [WIDTH-1:0]   b1,
   input  logic [WIDTH-1:0]   b1_t,
   output logic               ack0,
   output logic               ack0_t,
   output logic               ack1,
   output logic               ack1_t,
   output logic               done0,
   output logic               done0_t,
   output logic               done1,
   output logic               done1_t,
   output logic [2*WIDTH-1:0] result,
   output logic [2*WIDTH-1:0] result_t,
   output logic               busy,
   output logic               busy_t,
   output logic               mul_start,
   output logic               mul_start_t,
   output logic [WIDTH-1:0]   mul_multiplier,
   output logic [WIDTH-1:0]   mul_multiplier_t,
   output logic [WIDTH-1:0]   mul_multiplicand,
   output logic [WIDTH-1:0]   mul_multiplicand_t,
   input  logic [2*WIDTH-1:0] mul_product,
   input  logic [2*WIDTH-1:0] mul_product_t,
   input  logic               mul_done,
   input  logic               mul_done_t
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_nxt;
   logic   last, owner, sel_t, armed, done_t_q;
   logic   grant, gnt_id, capture;
   logic   req_t_any;

   assign req_t_any = req0_t | req1_t;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      gnt_id    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant     = 1'b1;
               // On a tie the requester not served last wins.
               gnt_id    = (req0 && req1) ? ~last : req1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: state_nxt = WAIT;
         WAIT: begin
            if (armed && mul_done) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last               <= 1'b0;
         owner              <= 1'b0;
         sel_t              <= 1'b0;
         armed              <= 1'b0;
         done_t_q           <= 1'b0;
         ack0               <= 1'b0;
         ack1               <= 1'b0;
         done0              <= 1'b0;
         done1              <= 1'b0;
         busy               <= 1'b0;
         mul_start          <= 1'b0;
         result             <= '0;
         result_t           <= '0;
         mul_multiplier     <= '0;
         mul_multiplier_t   <= '0;
         mul_multiplicand   <= '0;
         mul_multiplicand_t <= '0;
      end else begin
         ack0      <= grant & ~gnt_id;
         ack1      <= grant &  gnt_id;
         mul_start <= grant;
         done0     <= capture & ~owner;
         done1     <= capture &  owner;
         busy      <= (state_nxt != IDLE);

         if (grant) begin
            owner              <= gnt_id;
            sel_t              <= req_t_any;
            mul_multiplier     <= gnt_id ? a1 : a0;
            mul_multiplicand   <= gnt_id ? b1 : b0;
            mul_multiplier_t   <= (gnt_id ? a1_t : a0_t) | {WIDTH{req_t_any}};
            mul_multiplicand_t <= (gnt_id ? b1_t : b0_t) | {WIDTH{req_t_any}};
         end

         // A productDone still high from the previous job must be seen low first.
         if (state == LAUNCH)
            armed <= 1'b0;
         else if (state == WAIT && !mul_done)
            armed <= 1'b1;

         if (capture) begin
            result   <= mul_product;
            result_t <= mul_product_t | {2*WIDTH{sel_t}};
            done_t_q <= sel_t | mul_done_t;
         end

         if (state == DONE) begin
            last     <= owner;
            sel_t    <= 1'b0;
            done_t_q <= 1'b0;
         end
      end
   end

   assign ack0_t      = sel_t;
   assign ack1_t      = sel_t;
   assign mul_start_t = sel_t;
   assign busy_t      = sel_t;
   assign done0_t     = done_t_q;
   assign done1_t     = done_t_q;

endmodule
